fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one adder instance (range 2..8).
REQ-002 Parameter OPS_W, default 16, SHALL set the width of the completed-operation counter.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset; synchronous and active-high, shared with the adder instance.
REQ-005 req_a  input  32*NUM_REQ  SHALL carry operand A of requester i in bits [32i+31:32i].
REQ-006 req_b  input  32*NUM_REQ  SHALL carry operand B of requester i in the same packing as req_a.
REQ-007 req_stb  input  NUM_REQ  SHALL carry per-requester strobes: operands valid, held until acknowledged.
REQ-008 req_ack  output  NUM_REQ  SHALL carry the per-requester operand acknowledge, one-hot or zero.
REQ-009 rsp_z  output  32  SHALL carry the result to the current owner.
REQ-010 rsp_stb  output  NUM_REQ  SHALL carry the per-requester result strobe, one-hot or zero.
REQ-011 rsp_ack  input  NUM_REQ  SHALL carry the per-requester result acknowledge.
REQ-012 add_a, add_b  output  32 each  SHALL drive the adder operands; add_a_stb, add_b_stb  output  1 each.
REQ-013 add_a_ack, add_b_ack  input  1 each  SHALL be the adder operand acknowledges.
REQ-014 add_z  input  32, add_z_stb  input  1, add_z_ack  output  1  SHALL form the adder result port.
REQ-015 grant_id  output  3  SHALL give the current owner index; busy  output  1  SHALL be high outside IDLE.
REQ-016 ops_done  output  OPS_W  SHALL count completed operations.

Function
REQ-017 Every handshake SHALL transfer on a rising edge where both stb and ack are high; stb and ack SHALL be registered.
REQ-018 The FSM SHALL have states IDLE, GRANT, SEND_A, SEND_B, WAIT_Z, RESP.
REQ-019 In IDLE with any req_stb high, the block SHALL pick a winner round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap, then latch grant_id and enter GRANT.
REQ-020 In GRANT, req_ack[grant_id] SHALL be 1; on transfer, req_a/req_b of the winner SHALL be latched, ack dropped, and the FSM SHALL enter SEND_A.
REQ-021 In GRANT, if req_stb[grant_id] is low (withdrawn), the FSM SHALL return to IDLE without updating last_grant.
REQ-022 In SEND_A, add_a_stb SHALL be 1 with add_a stable; on transfer, add_a_stb SHALL drop and the FSM SHALL enter SEND_B. SEND_B SHALL behave the same with add_b, then enter WAIT_Z.
REQ-023 In WAIT_Z, add_z_ack SHALL be 1; on transfer, add_z SHALL be latched to rsp_z, add_z_ack dropped, and the FSM SHALL enter RESP.
REQ-024 In RESP, rsp_stb[grant_id] SHALL be 1 with rsp_z stable until transfer; then last_grant SHALL be set to grant_id, ops_done SHALL increment (wrapping at 2^OPS_W), and the FSM SHALL enter IDLE.
REQ-025 Only one operation SHALL be in flight; new requests SHALL be ignored (no ack) until IDLE.
REQ-026 Minimum overhead SHALL be IDLE→GRANT 1 cycle, GRANT transfer 1 cycle, RESP transfer 1 cycle, plus adder latency.
REQ-027 Operand or result values SHALL pass through bit-exact, including NaN, Inf and denormal encodings.
REQ-028 Strobes on non-granted requesters SHALL not affect the operation in progress.

Reset
REQ-029 On rst: state=IDLE, last_grant=NUM_REQ-1, all req_ack/rsp_stb/add_*_stb/add_z_ack=0, rsp_z=0, grant_id=0, busy=0, ops_done=0.
REQ-030 rst in any state SHALL abort the operation without a response; the adder SHALL be reset by the same rst in the same cycle.

Structure
REQ-031 The shared package fp_arb_pkg SHALL hold the state encodings, FP_W=32 and the NUM_REQ default.
REQ-032 Round-robin selection SHALL be one combinational sub-module rr_pick (inputs: request vector, last_grant; outputs: valid, index).

Verification
REQ-033 Scenario: req0 sends 0x3F800000 + 0x40000000 → rsp_stb[0] with rsp_z=0x40400000 and ops_done=1.
REQ-034 Scenario: after reset, req0 and req2 both strobe → req0 served first, then req2; grant order 0,2.
REQ-035 Scenario: all four requesters strobe continuously for 8 operations → grant order 0,1,2,3,0,1,2,3.
REQ-036 Scenario: req1 drops stb in GRANT → return to IDLE, no adder strobe, ops_done unchanged, next grant still searches from 1.
REQ-037 Scenario: rsp_ack delayed 5 cycles → rsp_z and rsp_stb held stable, no req_ack issued meanwhile.
REQ-038 Scenario: rst pulsed in WAIT_Z → all outputs at reset values next cycle, and the next request completes correctly (0xC0000000 + 0x40000000 → 0x00000000).

Source files
------------

// File: rtl/fp_arb_pkg.sv
// Shared definitions for the round-robin FP adder arbiter.
package fp_arb_pkg;
  localparam int FP_W        = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam int GID_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_SEND_A = 3'd2,
    ST_SEND_B = 3'd3,
    ST_WAIT_Z = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Operand pair latched from the winning requester.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } operands_t;
endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest distance after last_grant wins.
module rr_pick
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last_grant,
  output logic               vld,
  output logic [GID_W-1:0]   idx
);
  int d;
  int best;

  // Distance 0 is the slot right after last_grant; the nearest requester wins.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    d    = 0;
    best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + 2 * NUM_REQ - int'(last_grant) - 1) % NUM_REQ;
      if (req[i] && d < best) begin
        best = d;
        vld  = 1'b1;
        idx  = GID_W'(i);
      end
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one FP adder between NUM_REQ requesters, one operation at a time.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int OPS_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_stb,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [FP_W-1:0]         rsp_z,
  output logic [NUM_REQ-1:0]      rsp_stb,
  input  logic [NUM_REQ-1:0]      rsp_ack,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  output logic                    add_a_stb,
  output logic                    add_b_stb,
  input  logic                    add_a_ack,
  input  logic                    add_b_ack,
  input  logic [FP_W-1:0]         add_z,
  input  logic                    add_z_stb,
  output logic                    add_z_ack,
  output logic [GID_W-1:0]        grant_id,
  output logic                    busy,
  output logic [OPS_W-1:0]        ops_done
);
  state_e              state_q, state_d;
  logic [GID_W-1:0]    last_q, last_d;
  logic [GID_W-1:0]    gid_q, gid_d;
  operands_t           ops_q, ops_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]  rsp_stb_q, rsp_stb_d;
  logic                add_a_stb_q, add_a_stb_d;
  logic                add_b_stb_q, add_b_stb_d;
  logic                add_z_ack_q, add_z_ack_d;
  logic [FP_W-1:0]     rsp_z_q, rsp_z_d;
  logic [OPS_W-1:0]    ops_done_q, ops_done_d;

  logic                pick_vld;
  logic [GID_W-1:0]    pick_idx;
  operands_t           sel_ops;
  logic                own_stb, own_ack, own_rsp_stb, own_rsp_ack;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < NUM_REQ; i++) v[i] = (GID_W'(i) == id);
    return v;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_stb),
    .last_grant (last_q),
    .vld        (pick_vld),
    .idx        (pick_idx)
  );

  // Select the current owner's operands and handshake bits.
  always_comb begin
    sel_ops     = '0;
    own_stb     = 1'b0;
    own_ack     = 1'b0;
    own_rsp_stb = 1'b0;
    own_rsp_ack = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GID_W'(i) == gid_q) begin
        sel_ops.a   = req_a[i*FP_W +: FP_W];
        sel_ops.b   = req_b[i*FP_W +: FP_W];
        own_stb     = req_stb[i];
        own_ack     = req_ack_q[i];
        own_rsp_stb = rsp_stb_q[i];
        own_rsp_ack = rsp_ack[i];
      end
    end
  end

  // Next-state and registered-output logic; each handshake completes when stb & ack.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    ops_d       = ops_q;
    req_ack_d   = req_ack_q;
    rsp_stb_d   = rsp_stb_q;
    add_a_stb_d = add_a_stb_q;
    add_b_stb_d = add_b_stb_q;
    add_z_ack_d = add_z_ack_q;
    rsp_z_d     = rsp_z_q;
    ops_done_d  = ops_done_q;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        gid_d     = pick_idx;
        req_ack_d = onehot(pick_idx);
        state_d   = ST_GRANT;
      end
      ST_GRANT: begin
        if (!own_stb) begin
          // Requester withdrew: give up without moving the round-robin pointer.
          req_ack_d = '0;
          state_d   = ST_IDLE;
        end else if (own_ack) begin
          ops_d       = sel_ops;
          req_ack_d   = '0;
          add_a_stb_d = 1'b1;
          state_d     = ST_SEND_A;
        end
      end
      ST_SEND_A: if (add_a_stb_q && add_a_ack) begin
        add_a_stb_d = 1'b0;
        add_b_stb_d = 1'b1;
        state_d     = ST_SEND_B;
      end
      ST_SEND_B: if (add_b_stb_q && add_b_ack) begin
        add_b_stb_d = 1'b0;
        add_z_ack_d = 1'b1;
        state_d     = ST_WAIT_Z;
      end
      ST_WAIT_Z: if (add_z_ack_q && add_z_stb) begin
        rsp_z_d     = add_z;
        add_z_ack_d = 1'b0;
        rsp_stb_d   = onehot(gid_q);
        state_d     = ST_RESP;
      end
      ST_RESP: if (own_rsp_stb && own_rsp_ack) begin
        rsp_stb_d  = '0;
        last_d     = gid_q;
        ops_done_d = ops_done_q + OPS_W'(1);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; last_grant resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= GID_W'(NUM_REQ - 1);
      gid_q       <= '0;
      ops_q       <= '0;
      req_ack_q   <= '0;
      rsp_stb_q   <= '0;
      add_a_stb_q <= 1'b0;
      add_b_stb_q <= 1'b0;
      add_z_ack_q <= 1'b0;
      rsp_z_q     <= '0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gid_q       <= gid_d;
      ops_q       <= ops_d;
      req_ack_q   <= req_ack_d;
      rsp_stb_q   <= rsp_stb_d;
      add_a_stb_q <= add_a_stb_d;
      add_b_stb_q <= add_b_stb_d;
      add_z_ack_q <= add_z_ack_d;
      rsp_z_q     <= rsp_z_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign rsp_stb   = rsp_stb_q;
  assign rsp_z     = rsp_z_q;
  assign add_a     = ops_q.a;
  assign add_b     = ops_q.b;
  assign add_a_stb = add_a_stb_q;
  assign add_b_stb = add_b_stb_q;
  assign add_z_ack = add_z_ack_q;
  assign grant_id  = gid_q;
  assign busy      = (state_q != ST_IDLE);
  assign ops_done  = ops_done_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized self-checking bench for fp_add_arbiter with a stub adder.
module tb_fp_add_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*32-1:0]   req_a, req_b;
  logic [N-1:0]      req_stb, req_ack, rsp_stb, rsp_ack;
  logic [31:0]       rsp_z, add_a, add_b, add_z;
  logic              add_a_stb, add_b_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;
  logic [2:0]        grant_id;
  logic              busy;
  logic [15:0]       ops_done;

  int n_cmp = 0;
  int n_err = 0;
  int m_last;          // reference: index of last completed owner
  int m_ops;           // reference: completed operation count
  int grants[$];       // order of operand transfers observed
  logic [31:0] last_z; // rsp_z seen at the most recent response transfer

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .OPS_W(16)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb),
    .req_ack(req_ack), .rsp_z(rsp_z), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack), .add_z(add_z),
    .add_z_stb(add_z_stb), .add_z_ack(add_z_ack), .grant_id(grant_id),
    .busy(busy), .ops_done(ops_done)
  );

  // Stub adder: exact results for the named vectors, a bit scramble otherwise.
  function automatic logic [31:0] fn_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'hC0000000 && b == 32'h40000000) return 32'h00000000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
  endfunction

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 5))
      0: return {1'($urandom_range(0, 1)), 8'hFF, 1'b1, 22'($urandom)}; // NaN
      1: return {1'($urandom_range(0, 1)), 31'h7F800000};                // Inf
      2: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};        // denormal
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // Reference arbitration: first strobing requester after the last owner, wrapping.
  function automatic int rr_model(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  int          st, dly;
  logic [31:0] sa, sb;
  always @(posedge clk) begin
    if (rst) begin
      st <= 0; dly <= 0; add_a_ack <= 1'b0; add_b_ack <= 1'b0;
      add_z_stb <= 1'b0; add_z <= '0;
    end else begin
      case (st)
        0: if (add_a_stb && add_a_ack) begin sa <= add_a; add_a_ack <= 1'b0; st <= 1; end
           else if (add_a_stb) add_a_ack <= ($urandom_range(0, 2) == 0);
        1: if (add_b_stb && add_b_ack) begin
             sb <= add_b; add_b_ack <= 1'b0; dly <= $urandom_range(0, 3); st <= 2;
           end else if (add_b_stb) add_b_ack <= ($urandom_range(0, 2) == 0);
        2: if (dly == 0) begin add_z <= fn_add(sa, sb); add_z_stb <= 1'b1; st <= 3; end
           else dly <= dly - 1;
        default: if (add_z_stb && add_z_ack) begin add_z_stb <= 1'b0; st <= 0; end
      endcase
    end
  end

  // Serves c0..c3 operations from requesters 0..3, checking every cycle against the model.
  task automatic run_ops(input int c0, input int c1, input int c2, input int c3,
                         input int rsp_delay, input bit fix,
                         input logic [31:0] fa, input logic [31:0] fb);
    int cnt[N]; int issued[N]; logic [31:0] opa[N], opb[N];
    int total, done, cyc, dcnt, cur, pick;
    bit inflight, rx, tx;
    logic [31:0] ca, cb;
    cnt = '{c0, c1, c2, c3};
    total = 0; done = 0; cyc = 0; dcnt = 0; cur = 0; inflight = 0; ca = '0; cb = '0;
    for (int i = 0; i < N; i++) begin
      issued[i] = 0; total += cnt[i];
      opa[i] = rand_fp(); opb[i] = rand_fp();
      if (i == 0 && fix) begin opa[i] = fa; opb[i] = fb; end
      req_a[i*32 +: 32] = opa[i]; req_b[i*32 +: 32] = opb[i];
      req_stb[i] = (cnt[i] > 0);
    end
    while (done < total && cyc < 3000) begin
      @(negedge clk); cyc++;
      n_cmp++;
      if (ops_done !== 16'(m_ops)) begin n_err++; $display("FAIL ops_done got %0d want %0d", ops_done, m_ops); end
      if (inflight) begin
        n_cmp++;
        if (grant_id !== 3'(cur) || busy !== 1'b1 || req_ack !== '0) begin
          n_err++; $display("FAIL inflight grant_id=%0d busy=%b req_ack=%b want id %0d busy 1 ack 0", grant_id, busy, req_ack, cur);
        end
        if (add_a_stb) begin n_cmp++;
          if (add_a !== ca) begin n_err++; $display("FAIL add_a got %h want %h", add_a, ca); end end
        if (add_b_stb) begin n_cmp++;
          if (add_b !== cb) begin n_err++; $display("FAIL add_b got %h want %h", add_b, cb); end end
        if (rsp_stb !== '0) begin n_cmp++;
          if (rsp_stb !== 4'(1 << cur) || rsp_z !== fn_add(ca, cb)) begin
            n_err++; $display("FAIL rsp got stb=%b z=%h want stb=%b z=%h", rsp_stb, rsp_z, 4'(1 << cur), fn_add(ca, cb));
          end
        end
      end else begin
        n_cmp++;
        if (rsp_stb !== '0 || add_a_stb !== 1'b0 || add_b_stb !== 1'b0) begin
          n_err++; $display("FAIL idle_strobes rsp_stb=%b add_a_stb=%b add_b_stb=%b want 0", rsp_stb, add_a_stb, add_b_stb);
        end
      end
      tx = ((req_ack & req_stb) != '0); rx = 1'b0; pick = 0;
      if (tx) begin
        pick = rr_model(req_stb, m_last);
        n_cmp++;
        if (inflight || pick < 0 || (req_ack & req_stb) !== 4'(1 << pick)) begin
          n_err++; $display("FAIL grant got ack=%b want one-hot of %0d", req_ack & req_stb, pick);
          if (pick < 0) tx = 1'b0;
        end
      end
      if (inflight && rsp_stb[cur]) begin
        if (dcnt < rsp_delay) dcnt++;
        else begin rsp_ack = 4'(1 << cur); rx = 1'b1; last_z = rsp_z; end
      end
      @(posedge clk); #1;
      if (tx) begin
        inflight = 1; cur = pick; ca = opa[pick]; cb = opb[pick];
        grants.push_back(pick); issued[pick]++;
        if (issued[pick] < cnt[pick]) begin
          opa[pick] = rand_fp(); opb[pick] = rand_fp();
          req_a[pick*32 +: 32] = opa[pick]; req_b[pick*32 +: 32] = opb[pick];
        end else req_stb[pick] = 1'b0;
      end
      if (rx) begin
        rsp_ack = '0; inflight = 0; dcnt = 0; m_last = cur; m_ops++; done++;
      end
    end
    n_cmp++;
    if (done < total) begin n_err++; $display("FAIL timeout completed %0d want %0d", done, total); end
    req_stb = '0; rsp_ack = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_stb = '0; rsp_ack = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ack !== '0 || rsp_stb !== '0 || add_a_stb !== 1'b0 || add_b_stb !== 1'b0 ||
        add_z_ack !== 1'b0 || rsp_z !== '0 || grant_id !== '0 || busy !== 1'b0 || ops_done !== '0) begin
      n_err++; $display("FAIL reset_state ack=%b rstb=%b as=%b bs=%b zack=%b z=%h id=%0d busy=%b ops=%0d want all 0",
        req_ack, rsp_stb, add_a_stb, add_b_stb, add_z_ack, rsp_z, grant_id, busy, ops_done);
    end
    rst = 1'b0; m_last = N - 1; m_ops = 0; grants.delete();
  endtask

  task automatic test_single();
    test_reset();
    run_ops(1, 0, 0, 0, 0, 1'b1, 32'h3F800000, 32'h40000000);
    n_cmp++;
    if (last_z !== 32'h40400000) begin n_err++; $display("FAIL single_z got %h want 40400000", last_z); end
    @(negedge clk); n_cmp++;
    if (ops_done !== 16'd1) begin n_err++; $display("FAIL single_ops got %0d want 1", ops_done); end
  endtask

  task automatic test_pair();
    test_reset();
    run_ops(1, 0, 1, 0, 0, 1'b0, '0, '0);
    n_cmp++;
    if (grants.size() != 2 || grants[0] != 0 || grants[1] != 2) begin
      n_err++; $display("FAIL pair_order got %p want 0,2", grants);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    test_reset();
    run_ops(2, 2, 2, 2, 0, 1'b0, '0, '0);
    ok = (grants.size() == 8);
    foreach (grants[i]) if (grants[i] != i % N) ok = 0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rr_order got %p want 0,1,2,3,0,1,2,3", grants); end
  endtask

  task automatic test_withdraw();
    bit seen; int ops0;
    test_reset();
    run_ops(1, 0, 0, 0, 0, 1'b0, '0, '0);
    grants.delete(); ops0 = m_ops; seen = 0;
    req_a[63:32] = 32'h12345678; req_b[63:32] = 32'h9ABCDEF0; req_stb[1] = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (req_ack[1]) begin seen = 1; req_stb[1] = 1'b0; end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL withdraw_ack got none want req_ack[1]"); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); n_cmp++;
      if (add_a_stb !== 1'b0 || ops_done !== 16'(ops0)) begin
        n_err++; $display("FAIL withdraw_quiet add_a_stb=%b ops=%0d want 0 and %0d", add_a_stb, ops_done, ops0);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || req_ack !== '0) begin n_err++; $display("FAIL withdraw_idle busy=%b ack=%b want 0", busy, req_ack); end
    run_ops(0, 1, 1, 0, 0, 1'b0, '0, '0);
    n_cmp++;
    if (grants.size() < 1 || grants[0] != 1) begin n_err++; $display("FAIL withdraw_next got %p want first 1", grants); end
  endtask

  task automatic test_rsp_delay();
    test_reset();
    run_ops(1, 1, 1, 1, 5, 1'b0, '0, '0);
  endtask

  task automatic test_rst_wait_z();
    bit seen;
    test_reset(); seen = 0;
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h3F800000; req_stb[0] = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (add_z_ack) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL waitz_reach got no add_z_ack want 1"); end
    rst = 1'b1; req_stb = '0;
    @(negedge clk); n_cmp++;
    if (req_ack !== '0 || rsp_stb !== '0 || add_a_stb !== 1'b0 || add_b_stb !== 1'b0 ||
        add_z_ack !== 1'b0 || rsp_z !== '0 || grant_id !== '0 || busy !== 1'b0 || ops_done !== '0) begin
      n_err++; $display("FAIL waitz_reset zack=%b busy=%b ops=%0d rstb=%b want all 0", add_z_ack, busy, ops_done, rsp_stb);
    end
    rst = 1'b0; m_last = N - 1; m_ops = 0; grants.delete();
    run_ops(1, 0, 0, 0, 0, 1'b1, 32'hC0000000, 32'h40000000);
    n_cmp++;
    if (last_z !== 32'h00000000) begin n_err++; $display("FAIL waitz_after got %h want 00000000", last_z); end
  endtask

  task automatic test_random();
    test_reset();
    for (int r = 0; r < 6; r++)
      run_ops($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, 3), $urandom_range(0, 3), 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; req_stb = '0; rsp_ack = '0; req_a = '0; req_b = '0; last_z = '0;
    m_last = N - 1; m_ops = 0;
    test_reset();
    test_single();
    test_pair();
    test_round_robin();
    test_withdraw();
    test_rsp_delay();
    test_rst_wait_z();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
